// File: rtl/fetch_queue.sv
// Instruction fetch queue: prefetches words from a combinational IM into a
// DEPTH-entry FIFO of {PC+4, IR} pairs, flushed and refetched on redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int IM_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [IM_AW-1:0]         im_addr,
  input  logic [31:0]              im_data,
  input  logic                     deq,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_ir,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   fpcNext4;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pcMem [DEPTH];
  logic [31:0]   irMem [DEPTH];
  logic          notEmpty;
  logic          deqFire;
  logic          enq;

  assign fpcNext4 = fpc + 32'd4;
  assign notEmpty = (count != '0);
  assign deqFire  = deq && notEmpty && !redirect;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign enq      = !redirect && ((count < CNT_MAX) || deqFire);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc   <= 32'h0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect) begin
      fpc   <= redirect_pc & ~32'h3;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_ONE;
        fpc  <= fpcNext4;
      end
      if (deqFire) begin
        head <= head + PTR_ONE;
      end
      unique case ({enq, deqFire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; count gates every read, so stale
  // contents can never reach the outputs and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (enq) begin
      pcMem[tail] <= fpcNext4;
      irMem[tail] <= im_data;
    end
  end

  assign out_valid = notEmpty && !rst;
  assign out_pc    = out_valid ? pcMem[head] : 32'h0;
  assign out_ir    = out_valid ? irMem[head] : 32'h0;
  assign im_addr   = rst ? '0 : fpc[IM_AW+1:2];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model predicts the
// post-edge outputs; a monitor pops each prediction and compares it.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IM_AW = 5;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } entry_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] cnt;
    logic [31:0] addr;
  } expect_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             redirect = 1'b0;
  logic [31:0]      redirect_pc = 32'h0;
  logic             deq = 1'b0;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_data;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_ir;
  logic [CW-1:0]    count;

  logic [31:0] imem [2**IM_AW];
  entry_t      mq[$];
  logic [31:0] mfpc;
  expect_t     expQ[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  initial for (int k = 0; k < 2**IM_AW; k++) imem[k] = 32'(k + 100);
  assign im_data = imem[im_addr];

  fetch_queue #(.DEPTH(DEPTH), .IM_AW(IM_AW)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_addr(im_addr), .im_data(im_data), .deq(deq), .out_valid(out_valid),
    .out_pc(out_pc), .out_ir(out_ir), .count(count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, advance the model, predict outputs.
  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic d);
    expect_t e;
    logic    doDeq;
    @(negedge clk);
    rst = r; redirect = rd; redirect_pc = rpc; deq = d;
    if (r) begin
      mq.delete();
      mfpc = 32'h0;
    end else if (rd) begin
      mq.delete();
      mfpc = rpc & ~32'h3;
    end else begin
      doDeq = d && (mq.size() > 0);
      if (doDeq) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back('{pc: mfpc + 32'd4, ir: imem[(mfpc >> 2) % (2**IM_AW)]});
        mfpc = mfpc + 32'd4;
      end
    end
    e.valid = (mq.size() > 0);
    e.pc    = e.valid ? mq[0].pc : 32'h0;
    e.ir    = e.valid ? mq[0].ir : 32'h0;
    e.cnt   = 32'(mq.size());
    e.addr  = (mfpc >> 2) % (2**IM_AW);
    expQ.push_back(e);
    if (r) begin
      #1;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ir", out_ir, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      check("rst_addr", 32'(im_addr), 32'h0);
    end
  endtask

  // Monitor: pops one prediction per clock edge and compares the outputs.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        check("out_valid", 32'(out_valid), 32'(e.valid));
        check("count", 32'(count), e.cnt);
        check("im_addr", 32'(im_addr), e.addr);
        if (e.valid || out_valid) begin
          check("out_pc", out_pc, e.pc);
          check("out_ir", out_ir, e.ir);
        end else begin
          check("idle_pc", out_pc, 32'h0);
          check("idle_ir", out_ir, 32'h0);
        end
      end
    end
  end

  initial begin
    int waitCycles;
    // Streaming after reset
    repeat (2) cyc(1, 0, 0, 0);
    repeat (12) cyc(0, 0, 0, 1);
    // Fill, stall, one simultaneous enq/deq
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    // Redirect with three entries held
    cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h40, 1);
    cyc(0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 1);
    // Unaligned redirect then deq held through the empty cycle
    cyc(0, 1, 32'h4B, 0);
    repeat (4) cyc(0, 0, 0, 1);
    // Reset while full
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0);
    // IM aliasing and fpc wrap at 2^32
    cyc(0, 1, 32'h100, 0);
    repeat (2) cyc(0, 0, 0, 1);
    cyc(0, 1, 32'hFFFF_FFFC, 0);
    repeat (3) cyc(0, 0, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(49) == 0), ($urandom_range(9) == 0), $urandom,
          ($urandom_range(3) != 0));
    end
    repeat (20) cyc(0, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 1);
    @(negedge clk);
    deq = 1'b0;
    waitCycles = 0;
    while (expQ.size() != 0 && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    check("drain", 32'(expQ.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, queue entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter IM_AW, default 5, IM word-address width.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 The block SHALL have port redirect  input  1  taken branch or jump; flush the queue and refetch.
REQ-006 The block SHALL have port redirect_pc  input  32  target byte address when redirect=1.
REQ-007 The block SHALL have port im_addr  output  IM_AW  IM word address, equal to fpc[IM_AW+1:2].
REQ-008 The block SHALL have port im_data  input  32  combinational IM read data for im_addr.
REQ-009 The block SHALL have port deq  input  1  IF/ID consumes the head this cycle; deq=0 means a pipeline stall.
REQ-010 The block SHALL have port out_valid  output  1  the head entry is valid.
REQ-011 The block SHALL have port out_pc  output  32  PC+4 of the head instruction; this matches the IF/ID PC_in convention.
REQ-012 The block SHALL have port out_ir  output  32  the head instruction word.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1  number of valid entries.

Function
REQ-014 Internal fetch PC register fpc (32 bits): the block SHALL hold it word-aligned, with bits [1:0] always 0.
REQ-015 Entry format SHALL be {fpc+4, im_data}, captured in the same cycle that fpc addresses the IM.
REQ-016 The enqueue condition SHALL be enq = !redirect && (count<DEPTH || (deq && out_valid)).
- On enq, the block SHALL write the entry at the tail, advance the tail, and set fpc <= fpc+4.
REQ-017 The dequeue condition SHALL be deq && out_valid && !redirect.
- On dequeue, the block SHALL advance the head.
- deq while empty SHALL be ignored, with no underflow.
REQ-018 With enq and dequeue in the same cycle, count SHALL be unchanged; this applies when full, when partially filled, and when count=1.
REQ-019 Head and tail pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH and never go below 0.
REQ-020 Redirect SHALL have priority over all other events.
- Next cycle: count=0, head=tail=0, out_valid=0, fpc=redirect_pc with bits [1:0] forced to 0.
- The current im_data SHALL be discarded, and deq SHALL be ignored in the redirect cycle.
REQ-021 There SHALL be no bypass: an entry enqueued in cycle N SHALL be visible on out_* no earlier than cycle N+1.
REQ-022 out_valid SHALL equal (count!=0).
- When out_valid=0, out_ir SHALL be 32'h0 (NOP) and out_pc SHALL be 32'h0.
REQ-023 out_pc and out_ir SHALL be driven from the head entry storage and SHALL NOT depend combinationally on deq, redirect or im_data.
REQ-024 fpc SHALL wrap naturally at 2^32 with no overflow flag.
- im_addr SHALL alias modulo 2^IM_AW words.
REQ-025 When full and deq=0, fpc SHALL hold and the head entry SHALL hold stable.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL set fpc=0, head=tail=0 and count=0, and discard the entry contents.
REQ-027 rst SHALL have priority over redirect and deq.
REQ-028 During the rst=1 cycle and the cycle after, out_valid SHALL be 0, out_ir SHALL be 0, out_pc SHALL be 0 and im_addr SHALL be 0.
REQ-029 Reset mid-operation, including when full or during redirect, SHALL yield the same state as REQ-026, with no stale entry appearing.

Verification
REQ-030 Streaming: reset, then deq=1 continuously, with IM word k = k+100.
- Required response: the first out_valid is 1 cycle after reset release, with out_ir=100 and out_pc=4.
- Then one instruction per cycle: ir 101, 102, and so on, with pc 8, 12, and so on.
REQ-031 Fill/stall: deq=0 after reset.
- Required response: count reaches 4 after 4 cycles and holds; im_addr stays 4.
- out_ir stays 100; then deq=1 for 1 cycle gives out_ir=101 and count=4 (simultaneous enq/deq).
REQ-032 Redirect: with the queue holding 3 entries, pulse redirect=1, redirect_pc=32'h40, and deq=1.
- Required response: next cycle count=0, out_valid=0, im_addr=16.
- The cycle after: out_ir = IM word 16, out_pc=32'h44.
REQ-033 Unaligned redirect: redirect_pc=32'h4B -> fpc=32'h48, im_addr=18.
REQ-034 Empty deq: immediately after redirect, hold deq=1 -> count never below 0, and out_valid rises on the next cycle.
REQ-035 Reset while full: count=4, then rst=1 for 1 cycle -> count=0, im_addr=0; the next cycle out_ir=100 and out_pc=4.
